parzen_window_sequencer: RTL



---
 rtl/parzen_window_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/parzen_window_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parzen_window_sequencer                                                    |
// | Issues window positions to the ParzenWindow datapath and buffers results.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module parzen_window_sequencer #(
  parameter int WINDOW_SIZE_POW2 = 10,
  parameter int OUTPUT_INT       = 10,
  parameter int OUTPUT_FRAC      = 16,
  parameter int PIPE_LAT         = 3,
  parameter int FIFO_DEPTH       = 8,
  parameter int GAP_W            = 8,
  parameter int FRAME_W          = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic                              stop_i,
  input  logic [FRAME_W-1:0]                frames_i,
  input  logic [GAP_W-1:0]                  gap_i,
  output logic [WINDOW_SIZE_POW2-1:0]       tri_o,
  input  logic [OUTPUT_INT+OUTPUT_FRAC-1:0] win_i,
  output logic [OUTPUT_INT+OUTPUT_FRAC-1:0] win_o,
  output logic                              win_valid_o,
  input  logic                              win_ready_i,
  output logic                              win_last_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int c_dw     = OUTPUT_INT + OUTPUT_FRAC;
  localparam int c_cw     = $clog2(FIFO_DEPTH + PIPE_LAT + 2);
  localparam int c_aw     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_last_i = FIFO_DEPTH - 1;
  localparam logic [c_aw-1:0] c_last_idx = c_last_i[c_aw-1:0];
  localparam logic [c_cw-1:0] c_depth    = FIFO_DEPTH[c_cw-1:0];

  generate
    if (FIFO_DEPTH < PIPE_LAT + 1 || PIPE_LAT < 1) begin : g_bad_cfg
      $error("parzen_window_sequencer: need PIPE_LAT>=1 and FIFO_DEPTH>=PIPE_LAT+1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_GAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                      r_state;
  logic [WINDOW_SIZE_POW2-1:0] r_pos;
  logic [WINDOW_SIZE_POW2-1:0] r_tri;
  logic [FRAME_W-1:0]          r_frames;
  logic [FRAME_W-1:0]          r_frame_cnt;
  logic [GAP_W-1:0]            r_gap;
  logic [GAP_W-1:0]            r_gap_cnt;
  logic                        r_stop_pend;
  logic                        r_done;
  // Stage 0 is aligned with tri_o; stage PIPE_LAT is aligned with win_i.
  logic [PIPE_LAT:0]           r_tag_vld;
  logic [PIPE_LAT:0]           r_tag_last;
  logic [c_dw-1:0]             r_mem_data [FIFO_DEPTH];
  logic                        r_mem_last [FIFO_DEPTH];
  logic [c_aw-1:0]             r_wr_ptr;
  logic [c_aw-1:0]             r_rd_ptr;
  logic [c_cw-1:0]             r_count;

  logic [c_cw-1:0] w_inflight;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_wrap;
  logic            w_stop;
  logic            w_frames_done;
  logic            w_valid;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= PIPE_LAT; i++) begin
      w_inflight = w_inflight + {{(c_cw-1){1'b0}}, r_tag_vld[i]};
    end
  end

  assign w_issue       = (r_state == S_RUN) && ((w_inflight + r_count) < c_depth);
  assign w_push        = r_tag_vld[PIPE_LAT];
  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid && win_ready_i;
  assign w_wrap        = (r_pos == '1);
  assign w_stop        = r_stop_pend || stop_i;
  assign w_frames_done = (r_frames != '0) &&
                         (({1'b0, r_frame_cnt} + 1'b1) == {1'b0, r_frames});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_pos       <= '0;
      r_tri       <= '0;
      r_frames    <= '0;
      r_frame_cnt <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
      r_tag_vld   <= '0;
      r_tag_last  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_done     <= 1'b0;
      r_tag_vld  <= {r_tag_vld[PIPE_LAT-1:0], w_issue};
      r_tag_last <= {r_tag_last[PIPE_LAT-1:0], w_issue && w_wrap};

      if (w_issue) begin
        r_tri <= r_pos;
        r_pos <= r_pos + 1'b1;
      end

      if (w_push) r_wr_ptr <= (r_wr_ptr == c_last_idx) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_last_idx) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (stop_i && r_state != S_IDLE) r_stop_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_frames    <= frames_i;
            r_gap       <= gap_i;
            r_pos       <= '0;
            r_frame_cnt <= '0;
            r_gap_cnt   <= '0;
            r_stop_pend <= stop_i;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue && w_wrap) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_stop || w_frames_done) begin
              r_stop_pend <= 1'b0;
              r_state     <= S_DRAIN;
            end else if (r_gap != '0) begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (w_stop) begin
            r_stop_pend <= 1'b0;
            r_state     <= S_DRAIN;
          end else if ((r_gap_cnt + 1'b1) == r_gap) begin
            r_state <= S_RUN;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_inflight == '0 && r_count == '0) begin
            r_stop_pend <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= win_i;
      r_mem_last[r_wr_ptr] <= r_tag_last[PIPE_LAT];
    end
  end

  assign tri_o       = r_tri;
  assign win_valid_o = w_valid;
  assign win_o       = w_valid ? r_mem_data[r_rd_ptr] : '0;
  assign win_last_o  = w_valid && r_mem_last[r_rd_ptr];
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;

endmodule
`default_nettype wire
